ucode_sequencer: RTL and testbench

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

---
 rtl/ucode_pkg.sv | 35 +++
 rtl/ustack.sv | 44 ++++
 rtl/ucode_sequencer.sv | 140 ++++++++++++++
 tb/tb_ucode_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// rtl/ucode_pkg.sv - microword field layout, branch-condition and opcode encodings, sequencer states
package ucode_pkg;

    // Field positions above the offset field; add UPC_W to get the absolute bit index.
    localparam int JCOND_POS = 0;
    localparam int CINV_POS  = 3;
    localparam int OP_POS    = 4;
    localparam int CLR_POS   = 6;
    localparam int EN_POS    = 7;
    localparam int CTRL_POS  = 8;

    typedef enum logic [2:0] {
        JC_NEVER  = 3'b000,
        JC_ALWAYS = 3'b001,
        JC_Z      = 3'b010,
        JC_N      = 3'b011,
        JC_C      = 3'b100,
        JC_P      = 3'b101,
        JC_INT    = 3'b110,
        JC_NEVER2 = 3'b111
    } jcond_e;

    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_CALL   = 2'b01,
        OP_RET    = 2'b10,
        OP_HALT   = 2'b11
    } op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/ustack.sv
// rtl/ustack.sv - micro-return LIFO; push ignored when full, pop ignored when empty
module ustack #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [0:(1 << AW) - 1];
    logic [SPW-1:0]   sp;

    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);
    assign pop_data = mem[AW'(sp - SPW'(1))];

    // stack pointer: count of valid entries
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    // entry storage; contents need no reset because sp guards every read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[AW'(sp)] <= push_data;
        end
    end

endmodule

// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - microcode sequencer with conditional branch, call/return stack and halt/interrupt
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int  OPCODE_W    = 5,
    parameter int  UPC_W       = 3,
    parameter int  CTRL_W      = 21,
    parameter int  STACK_DEPTH = 4,
    localparam int UW          = CTRL_W + UPC_W + 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OPCODE_W-1:0]       OPCODE,
    input  logic                      C,
    input  logic                      N,
    input  logic                      P,
    input  logic                      Z,
    input  logic                      INT,
    input  logic                      stall,
    input  logic [UW-1:0]             uword,
    output logic [OPCODE_W+UPC_W-1:0] uaddr,
    output logic [CTRL_W-1:0]         ctrl,
    output logic                      int_ack,
    output logic                      halted,
    output logic                      err_ovf,
    output logic                      err_udf
);

    state_e           state, state_nxt;
    logic [UPC_W-1:0] upc, upc_nxt, upc_inc, pop_data;
    logic [UPC_W-1:0] f_offset;
    jcond_e           f_jcond;
    op_e              f_op;
    logic             f_cinv, f_clr, f_en;
    logic             int_pend, sel_cond, cond, advance, push, pop;
    logic             stk_full, stk_empty;

    assign f_offset = uword[UPC_W-1:0];
    assign f_jcond  = jcond_e'(uword[UPC_W+JCOND_POS +: 3]);
    assign f_cinv   = uword[UPC_W+CINV_POS];
    assign f_op     = op_e'(uword[UPC_W+OP_POS +: 2]);
    assign f_clr    = uword[UPC_W+CLR_POS];
    assign f_en     = uword[UPC_W+EN_POS];

    assign upc_inc  = upc + UPC_W'(1);
    assign uaddr    = {OPCODE, upc};
    assign advance  = (state == ST_RUN) && !stall && f_en;
    assign cond     = sel_cond ^ f_cinv;

    // clear overrides the opcode, so neither stack port fires on a clr microstep
    assign push     = advance && !f_clr && (f_op == OP_CALL) && cond;
    assign pop      = advance && !f_clr && (f_op == OP_RET);
    assign int_ack  = advance && !f_clr && ((f_op == OP_BRANCH) || (f_op == OP_CALL)) &&
                      (f_jcond == JC_INT) && cond;

    ustack #(
        .WIDTH (UPC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .pop_data  (pop_data),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // condition select before optional inversion
    always_comb begin
        sel_cond = 1'b0;
        case (f_jcond)
            JC_ALWAYS: sel_cond = 1'b1;
            JC_Z:      sel_cond = Z;
            JC_N:      sel_cond = N;
            JC_C:      sel_cond = C;
            JC_P:      sel_cond = P;
            JC_INT:    sel_cond = int_pend;
            default:   sel_cond = 1'b0;
        endcase
    end

    // next micro-PC; holds unless advancing
    always_comb begin
        upc_nxt = upc;
        if (advance) begin
            if (f_clr) begin
                upc_nxt = '0;
            end else begin
                case (f_op)
                    OP_BRANCH, OP_CALL: upc_nxt = cond ? f_offset : upc_inc;
                    OP_RET:             upc_nxt = stk_empty ? '0 : pop_data;
                    default:            upc_nxt = upc_inc;
                endcase
            end
        end
    end

    // micro-PC, pending interrupt and sticky stack error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            upc      <= '0;
            int_pend <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else begin
            upc      <= upc_nxt;
            int_pend <= INT | (int_pend & ~int_ack);
            err_ovf  <= err_ovf | (push & stk_full);
            err_udf  <= err_udf | (pop & stk_empty);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: halt on an advancing HALT microword, leave on a pending interrupt
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (advance && !f_clr && (f_op == OP_HALT)) state_nxt = ST_HALT;
            ST_HALT: if (int_pend) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // state-decoded outputs: control field is blanked while halted
    always_comb begin
        halted = (state == ST_HALT);
        ctrl   = halted ? '0 : uword[UW-1:UPC_W+CTRL_POS];
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb/tb_ucode_sequencer.sv - self-checking bench for ucode_sequencer against a queue-based reference model
module tb_ucode_sequencer;

    localparam int OW    = 5;
    localparam int PW    = 3;
    localparam int CW    = 21;
    localparam int UW    = CW + PW + 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [OW-1:0] OPCODE;
    logic          C, N, P, Z, INT, stall;
    logic [UW-1:0] uword;
    logic [OW+PW-1:0] uaddr;
    logic [CW-1:0] ctrl;
    logic          int_ack, halted, err_ovf, err_udf;

    int total = 0;
    int bad   = 0;

    int m_upc;
    int stk[$];
    bit m_halt, m_pend, m_ovf, m_udf;

    ucode_sequencer #(
        .OPCODE_W    (OW),
        .UPC_W       (PW),
        .CTRL_W      (CW),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .OPCODE  (OPCODE),
        .C       (C),
        .N       (N),
        .P       (P),
        .Z       (Z),
        .INT     (INT),
        .stall   (stall),
        .uword   (uword),
        .uaddr   (uaddr),
        .ctrl    (ctrl),
        .int_ack (int_ack),
        .halted  (halted),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(int off, int jc, int cinv, int op, int clr, int en, int ctl);
        return 32'((ctl << 11) | (en << 10) | (clr << 9) | (op << 7) | (cinv << 6) | (jc << 3) | off);
    endfunction

    function automatic logic [31:0] cur_upc();
        return 32'(uaddr[PW-1:0]);
    endfunction

    // Called just after a falling edge with inputs applied: check outputs, clock once, advance model.
    task automatic cyc();
        int unsigned u;
        int off, jc, cinv, op, clr, en, ctl;
        bit sel, cond, adv, ack, np;
        #1;
        u    = uword;
        off  = int'(u & 7);
        jc   = int'((u >> 3) & 7);
        cinv = int'((u >> 6) & 1);
        op   = int'((u >> 7) & 3);
        clr  = int'((u >> 9) & 1);
        en   = int'((u >> 10) & 1);
        ctl  = int'(u >> 11);
        case (jc)
            1:       sel = 1'b1;
            2:       sel = (Z === 1'b1);
            3:       sel = (N === 1'b1);
            4:       sel = (C === 1'b1);
            5:       sel = (P === 1'b1);
            6:       sel = m_pend;
            default: sel = 1'b0;
        endcase
        cond = sel ^ (cinv != 0);
        adv  = !m_halt && (stall === 1'b0) && (en != 0);
        ack  = adv && (clr == 0) && (op < 2) && (jc == 6) && cond;
        check_eq("uaddr",   32'(uaddr),   32'(int'(OPCODE) * 8 + m_upc));
        check_eq("ctrl",    32'(ctrl),    m_halt ? 32'd0 : 32'(ctl));
        check_eq("int_ack", 32'(int_ack), 32'(ack));
        check_eq("halted",  32'(halted),  32'(m_halt));
        check_eq("err_ovf", 32'(err_ovf), 32'(m_ovf));
        check_eq("err_udf", 32'(err_udf), 32'(m_udf));
        @(posedge clk);
        if (rst === 1'b0) begin
            m_upc = 0; stk.delete(); m_halt = 0; m_pend = 0; m_ovf = 0; m_udf = 0;
        end else begin
            np = (INT === 1'b1) || (m_pend && !ack);
            if (m_halt) begin
                if (m_pend) m_halt = 0;
            end else if (adv) begin
                if (clr != 0) begin
                    m_upc = 0;
                end else begin
                    case (op)
                        0: m_upc = cond ? off : (m_upc + 1) % 8;
                        1: begin
                            if (cond) begin
                                if (stk.size() < DEPTH) stk.push_back((m_upc + 1) % 8);
                                else m_ovf = 1;
                                m_upc = off;
                            end else begin
                                m_upc = (m_upc + 1) % 8;
                            end
                        end
                        2: begin
                            if (stk.size() == 0) begin m_upc = 0; m_udf = 1; end
                            else m_upc = stk.pop_back();
                        end
                        default: begin m_halt = 1; m_upc = (m_upc + 1) % 8; end
                    endcase
                end
            end
            m_pend = np;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [31:0] w);
        uword = w;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(mk(0, 0, 0, 0, 0, 1, 0));
        rst = 1'b1;
    endtask

    initial begin
        OPCODE = 5'h13; C = 0; N = 0; P = 0; Z = 0; INT = 0; stall = 0;
        rst = 1'b0; uword = '0;
        m_upc = 0; m_halt = 0; m_pend = 0; m_ovf = 0; m_udf = 0;
        @(posedge clk);
        @(negedge clk);

        // reset in the middle of a taken CALL
        rst = 1'b1;
        step(mk(2, 1, 0, 0, 0, 1, 5));
        check_eq("pre_rst_upc", cur_upc(), 32'd2);
        rst = 1'b0;
        step(mk(6, 1, 0, 1, 0, 1, 5));
        check_eq("rst_upc", cur_upc(), 32'd0);
        check_eq("rst_uaddr", 32'(uaddr), 32'h98);
        check_eq("rst_ovf", 32'(err_ovf), 32'd0);
        check_eq("rst_udf", 32'(err_udf), 32'd0);
        rst = 1'b1;

        // inverted Z branch
        step(mk(3, 1, 0, 0, 0, 1, 0));
        Z = 0;
        step(mk(5, 2, 1, 0, 0, 1, 7));
        check_eq("br_z0_taken", cur_upc(), 32'd5);
        step(mk(3, 1, 0, 0, 0, 1, 0));
        Z = 1;
        step(mk(5, 2, 1, 0, 0, 1, 7));
        check_eq("br_z1_fall", cur_upc(), 32'd4);
        Z = 0;
        step(mk(7, 1, 0, 0, 0, 1, 0));
        step(mk(1, 0, 0, 0, 0, 1, 0));
        check_eq("br_wrap", cur_upc(), 32'd0);

        // call / return / underflow
        step(mk(2, 1, 0, 0, 0, 1, 0));
        step(mk(6, 1, 0, 1, 0, 1, 0));
        check_eq("call_jump", cur_upc(), 32'd6);
        step(mk(0, 0, 0, 2, 0, 1, 0));
        check_eq("ret_addr", cur_upc(), 32'd3);
        step(mk(0, 0, 0, 2, 0, 1, 0));
        check_eq("ret_empty_upc", cur_upc(), 32'd0);
        check_eq("ret_empty_udf", 32'(err_udf), 32'd1);

        // overflow with five nested calls
        do_reset();
        for (int i = 1; i <= 5; i++) step(mk(i, 1, 0, 1, 0, 1, 0));
        check_eq("ovf_jump", cur_upc(), 32'd5);
        check_eq("ovf_flag", 32'(err_ovf), 32'd1);
        for (int i = 4; i >= 1; i--) begin
            step(mk(0, 0, 0, 2, 0, 1, 0));
            check_eq("ovf_ret", cur_upc(), 32'(i));
        end
        check_eq("ovf_no_udf", 32'(err_udf), 32'd0);

        // halt and interrupt wake-up
        do_reset();
        step(mk(5, 1, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 3, 0, 1, 21'h1ABCD));
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_ctrl", 32'(ctrl), 32'd0);
        check_eq("halt_upc", cur_upc(), 32'd6);
        step(mk(0, 0, 0, 3, 0, 1, 21'h1ABCD));
        check_eq("halt_hold", 32'(halted), 32'd1);
        INT = 1;
        step(mk(0, 0, 0, 3, 0, 1, 21'h1ABCD));
        INT = 0;
        check_eq("halt_pend", 32'(halted), 32'd1);
        step(mk(0, 0, 0, 3, 0, 1, 21'h1ABCD));
        check_eq("wake_run", 32'(halted), 32'd0);
        check_eq("wake_upc", cur_upc(), 32'd6);
        uword = mk(2, 6, 0, 0, 0, 1, 0);
        #1 check_eq("int_ack_hi", 32'(int_ack), 32'd1);
        cyc();
        check_eq("int_br_upc", cur_upc(), 32'd2);
        uword = mk(2, 6, 0, 0, 0, 1, 0);
        #1 check_eq("int_ack_clr", 32'(int_ack), 32'd0);
        cyc();
        check_eq("int_fall_upc", cur_upc(), 32'd3);

        // stall on a taken CALL
        do_reset();
        step(mk(1, 1, 0, 0, 0, 1, 0));
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            uword = mk(6, 1, 0, 1, 0, 1, 0);
            #1 check_eq("stall_ack", 32'(int_ack), 32'd0);
            cyc();
            check_eq("stall_upc", cur_upc(), 32'd1);
        end
        stall = 0;
        step(mk(6, 1, 0, 1, 0, 1, 0));
        check_eq("unstall_call", cur_upc(), 32'd6);
        step(mk(0, 0, 0, 2, 0, 1, 0));
        check_eq("unstall_ret", cur_upc(), 32'd2);
        step(mk(0, 0, 0, 2, 0, 1, 0));
        check_eq("single_push", 32'(err_udf), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            rst    = ($urandom_range(0, 49) != 0);
            stall  = ($urandom_range(0, 3) == 0);
            INT    = ($urandom_range(0, 9) == 0);
            C      = 1'($urandom);
            N      = 1'($urandom);
            P      = 1'($urandom);
            Z      = 1'($urandom);
            OPCODE = OW'($urandom);
            w      = $urandom;
            w[10]  = ($urandom_range(0, 7) != 0);
            w[9]   = ($urandom_range(0, 7) == 0);
            step(w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
